gerador_paridade_quadro: RTL

Parametrised serial parity framer. It consumes a bit stream through a valid/ready handshake and forwards each data bit. After every DATA_BITS data bits it inserts one parity bit (even or odd, chosen at run time). The block sits between a serial data source and a serial line driver. It generalises the single-bit even-parity FSM to framed words, selectable polarity, backpressure and frame counting.

---
 rtl/gerador_paridade_quadro.sv | 115 +++++++++++
 1 files changed

// File: rtl/gerador_paridade_quadro.sv
`timescale 1ns/1ps
// Serial parity framer: forwards DATA_BITS data bits, then inserts one parity bit.
// Defining PARITY_CHECK_EN turns it into a checker that consumes the received parity bit and flags mismatches.
module gerador_paridade_quadro #(
    parameter int DATA_BITS   = 8,
    parameter int CNT_W       = $clog2(DATA_BITS) + 1,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   odd_sel,
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic                   out_bit,
    input  logic                   out_ready,
    output logic                   out_is_par,
    output logic                   run_par,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef PARITY_CHECK_EN
    ,
    output logic                   parity_err
`endif
);

    typedef enum logic {
        DATA,
        PARITY
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             odd_q;
    logic             load;

    // The single output register may be refilled when empty or being drained.
    assign load    = !out_valid || out_ready;
    assign run_par = acc;

`ifdef PARITY_CHECK_EN
    assign in_ready = load;
`else
    assign in_ready = load && (state == DATA);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DATA;
            cnt        <= '0;
            acc        <= 1'b0;
            odd_q      <= 1'b0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            out_is_par <= 1'b0;
            frame_cnt  <= '0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else if (load) begin
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            case (state)
                DATA: begin
                    if (in_valid) begin
                        out_bit    <= in_bit;
                        out_valid  <= 1'b1;
                        out_is_par <= 1'b0;
                        acc        <= acc ^ in_bit;
                        // Polarity is latched once per frame so mid-frame changes are ignored.
                        if (cnt == '0) begin
                            odd_q <= odd_sel;
                        end
                        if (cnt == LAST_BIT) begin
                            cnt   <= '0;
                            state <= PARITY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                PARITY: begin
`ifdef PARITY_CHECK_EN
                    if (in_valid) begin
                        out_bit    <= in_bit;
                        out_is_par <= 1'b1;
                        out_valid  <= 1'b1;
                        parity_err <= in_bit != (acc ^ odd_q);
                        acc        <= 1'b0;
                        frame_cnt  <= frame_cnt + 1'b1;
                        state      <= DATA;
                    end else begin
                        out_valid <= 1'b0;
                    end
`else
                    out_bit    <= acc ^ odd_q;
                    out_is_par <= 1'b1;
                    out_valid  <= 1'b1;
                    acc        <= 1'b0;
                    frame_cnt  <= frame_cnt + 1'b1;
                    state      <= DATA;
`endif
                end
                default: state <= DATA;
            endcase
        end
    end

endmodule
